// File: rtl/coord_pkg.sv
// Shared definitions for the coordinate attribute fetch path.
// Format codes are common with the coordinate formatter.
package coord_pkg;

   localparam logic [2:0] FMT_U8    = 3'd0;
   localparam logic [2:0] FMT_S8    = 3'd1;
   localparam logic [2:0] FMT_U16   = 3'd2;
   localparam logic [2:0] FMT_S16   = 3'd3;
   localparam logic [2:0] FMT_FLOAT = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GATHER,
      ST_CONVERT,
      ST_OUTPUT
   } state_t;

   function automatic logic [2:0] fmt_size(input logic [2:0] f);
      case (f)
         FMT_U8, FMT_S8:   return 3'd1;
         FMT_U16, FMT_S16: return 3'd2;
         default:          return 3'd4;
      endcase
   endfunction

   function automatic logic fmt_ok(input logic [2:0] f);
      return f <= FMT_FLOAT;
   endfunction

endpackage

// File: rtl/byte_stream_buf.sv
// Byte FIFO: 32-bit big-endian push, 0/1/2/4-byte pop, head window.
// Head is always mem[0]; a pop shifts the remaining bytes down.
module byte_stream_buf #(
   parameter int BUF_BYTES = 8,
   localparam int CW = $clog2(BUF_BYTES + 1),
   localparam int AW = $clog2(BUF_BYTES)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush,
   input  logic          push,
   input  logic [31:0]   push_data,
   input  logic [2:0]    pop_n,
   output logic          space,
   output logic [31:0]   head,
   output logic [CW-1:0] count
);

   logic [7:0]    mem [BUF_BYTES];
   logic [7:0]    nxt [BUF_BYTES];
   logic [CW-1:0] base;
   logic [CW-1:0] count_nxt;

   assign space = resetn && (count <= CW'(BUF_BYTES - 4));
   assign head  = {mem[0], mem[1], mem[2], mem[3]};

   always_comb begin
      base = flush ? '0 : count - CW'(pop_n);
      for (int i = 0; i < BUF_BYTES; i++) begin
         nxt[AW'(i)] = 8'h00;
         if (i + int'(pop_n) < BUF_BYTES)
            nxt[AW'(i)] = mem[AW'(i + int'(pop_n))];
      end
      // a simultaneous push lands right behind the surviving bytes
      if (push) begin
         for (int k = 0; k < 4; k++)
            nxt[AW'(int'(base) + k)] = push_data[31-8*k -: 8];
      end
      count_nxt = base + (push ? CW'(4) : '0);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
         for (int i = 0; i < BUF_BYTES; i++)
            mem[AW'(i)] <= 8'h00;
      end else begin
         count <= count_nxt;
         for (int i = 0; i < BUF_BYTES; i++)
            mem[AW'(i)] <= nxt[AW'(i)];
      end
   end

endmodule

// File: rtl/coord_attr_fetcher.sv
// Slices 2/3 raw components from the vertex byte stream, runs each
// through the formatter and returns the float result on a handshake.
module coord_attr_fetcher
   import coord_pkg::*;
#(
   parameter int BUF_BYTES = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        attr_start,
   input  logic [2:0]  cfg_format,
   input  logic        cfg_three,
   input  logic [4:0]  cfg_shift,
   input  logic        flush,
   output logic        busy,
   output logic        err,
   input  logic        word_valid,
   input  logic [31:0] word_data,
   output logic        word_ready,
   output logic        fmt_start,
   output logic [31:0] fmt_data,
   output logic [2:0]  fmt_format,
   output logic [4:0]  fmt_shift,
   input  logic        fmt_valid,
   input  logic [31:0] fmt_result,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [1:0]  out_index,
   output logic        out_last,
   input  logic        out_ready
);

   localparam int CW = $clog2(BUF_BYTES + 1);

   state_t        state;
   logic          three_q;
   logic [1:0]    comp;
   logic [2:0]    size;
   logic [2:0]    pop_n;
   logic          take;
   logic [31:0]   head;
   logic [31:0]   raw;
   logic [CW-1:0] count;

   assign size  = fmt_size(fmt_format);
   assign take  = (state == ST_GATHER) && (count >= CW'(size));
   assign pop_n = take ? size : 3'd0;

   always_comb begin
      raw = head;
      if (size == 3'd1)
         raw = {24'h0, head[31:24]};
      else if (size == 3'd2)
         raw = {16'h0, head[31:16]};
   end

   byte_stream_buf #(
      .BUF_BYTES(BUF_BYTES)
   ) u_buf (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush && state == ST_IDLE),
      .push     (word_valid && word_ready),
      .push_data(word_data),
      .pop_n    (pop_n),
      .space    (word_ready),
      .head     (head),
      .count    (count)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         three_q    <= 1'b0;
         comp       <= 2'd0;
         busy       <= 1'b0;
         err        <= 1'b0;
         fmt_start  <= 1'b0;
         fmt_data   <= 32'h0;
         fmt_format <= 3'd0;
         fmt_shift  <= 5'd0;
         out_valid  <= 1'b0;
         out_data   <= 32'h0;
         out_index  <= 2'd0;
         out_last   <= 1'b0;
      end else begin
         err       <= 1'b0;
         fmt_start <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (attr_start && fmt_ok(cfg_format)) begin
                  fmt_format <= cfg_format;
                  fmt_shift  <= cfg_shift;
                  three_q    <= cfg_three;
                  comp       <= 2'd0;
                  busy       <= 1'b1;
                  state      <= ST_GATHER;
               end else if (attr_start) begin
                  err <= 1'b1;
               end
            end
            ST_GATHER: begin
               if (take) begin
                  fmt_data  <= raw;
                  fmt_start <= 1'b1;
                  state     <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               if (fmt_valid) begin
                  out_data  <= fmt_result;
                  out_valid <= 1'b1;
                  out_index <= comp;
                  out_last  <= comp == (three_q ? 2'd2 : 2'd1);
                  state     <= ST_OUTPUT;
               end
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     comp  <= comp + 2'd1;
                     state <= ST_GATHER;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coord_attr_fetcher.sv
// Bench for coord_attr_fetcher: byte-queue reference model plus a
// behavioural formatter (FLOAT same cycle, integers two cycles later).
module tb_coord_attr_fetcher;
   import coord_pkg::*;

   localparam int BUF = 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        attr_start = 1'b0;
   logic [2:0]  cfg_format = 3'd0;
   logic        cfg_three = 1'b0;
   logic [4:0]  cfg_shift = 5'd0;
   logic        flush = 1'b0;
   logic        busy, err;
   logic        word_valid = 1'b0;
   logic [31:0] word_data = 32'h0;
   logic        word_ready;
   logic        fmt_start;
   logic [31:0] fmt_data;
   logic [2:0]  fmt_format;
   logic [4:0]  fmt_shift;
   logic        fmt_valid;
   logic [31:0] fmt_result;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_index;
   logic        out_last;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   coord_attr_fetcher #(.BUF_BYTES(BUF)) dut (
      .clk(clk), .resetn(resetn), .attr_start(attr_start),
      .cfg_format(cfg_format), .cfg_three(cfg_three),
      .cfg_shift(cfg_shift), .flush(flush), .busy(busy), .err(err),
      .word_valid(word_valid), .word_data(word_data),
      .word_ready(word_ready), .fmt_start(fmt_start),
      .fmt_data(fmt_data), .fmt_format(fmt_format),
      .fmt_shift(fmt_shift), .fmt_valid(fmt_valid),
      .fmt_result(fmt_result), .out_valid(out_valid),
      .out_data(out_data), .out_index(out_index),
      .out_last(out_last), .out_ready(out_ready)
   );

   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // formatter stand-in
   function automatic logic [31:0] conv(input logic [31:0] r,
                                        input logic [2:0] f,
                                        input logic [4:0] s);
      if (f == FMT_FLOAT) return r;
      return (r << 3) ^ {f, s, 24'h5A5A5A};
   endfunction

   logic [1:0] fpipe;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) fpipe <= 2'b00;
      else fpipe <= {fpipe[0], fmt_start && fmt_format != FMT_FLOAT};
   end
   assign fmt_valid  = (fmt_start && fmt_format == FMT_FLOAT) || fpipe[1];
   assign fmt_result = conv(fmt_data, fmt_format, fmt_shift);

   // reference model state
   logic [31:0] word_q[$];
   logic [7:0]  ref_q[$];
   logic [2:0]  m_fmt;
   logic        m_three;
   logic [4:0]  m_shift;
   int          m_comp;
   int          outstanding = 0;
   logic [31:0] m_raw, e_data;
   logic [1:0]  e_idx;
   logic        e_last;
   int          cyc = 0;
   int          start_cyc = 0;
   logic        prev_ov = 1'b0;
   int          rdy_mode = 0;
   bit          feed_en = 1'b1;
   bit          feed_rand = 1'b0;

   function automatic int m_size(input logic [2:0] f);
      if (f == FMT_FLOAT) return 4;
      return (f >= FMT_U16) ? 2 : 1;
   endfunction

   // input drivers, just after each rising edge
   always @(posedge clk) begin
      #1;
      word_valid = feed_en && word_q.size() > 0 &&
                   (!feed_rand || $urandom_range(3) != 0);
      word_data  = (word_q.size() > 0) ? word_q[0] : 32'h0;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = $urandom_range(9) < 7;
      else out_ready = 1'b0;
   end

   // monitor, away from the active edge
   always @(negedge clk) begin
      cyc++;
      if (resetn) begin
         if (fmt_start) begin
            check("fmt_once", outstanding, 0);
            outstanding = 1;
            m_raw = 32'h0;
            for (int k = 0; k < m_size(m_fmt); k++) begin
               if (ref_q.size() == 0) check("ref_underflow", 1, 0);
               else m_raw = (m_raw << 8) | 32'(ref_q.pop_front());
            end
            check("fmt_data", fmt_data, m_raw);
            check("fmt_format", 32'(fmt_format), 32'(m_fmt));
            check("fmt_shift", 32'(fmt_shift), 32'(m_shift));
            e_data = conv(m_raw, m_fmt, m_shift);
            e_idx = 2'(m_comp);
            e_last = m_comp == (m_three ? 2 : 1);
            start_cyc = cyc;
         end
         if (fmt_valid) check("fmt_hold", fmt_data, m_raw);
         if (out_valid && !prev_ov)
            check("latency", cyc - start_cyc, (m_fmt == FMT_FLOAT) ? 1 : 3);
         if (out_valid) begin
            check("out_data", out_data, e_data);
            check("out_index", 32'(out_index), 32'(e_idx));
            check("out_last", 32'(out_last), 32'(e_last));
         end
         if (out_valid && out_ready) begin
            outstanding = 0;
            m_comp++;
         end
         if (flush && !busy) ref_q.delete();
         if (word_valid && word_ready) begin
            for (int k = 0; k < 4; k++)
               ref_q.push_back(word_data[31-8*k -: 8]);
            void'(word_q.pop_front());
         end
         prev_ov = out_valid;
      end
   end

   function automatic logic [31:0] dut_count();
      return 32'(dut.u_buf.count);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_attr(input logic [2:0] f, input logic t,
                             input logic [4:0] s);
      logic was_busy;
      was_busy = busy;
      cfg_format = f;
      cfg_three  = t;
      cfg_shift  = s;
      attr_start = 1'b1;
      if (fmt_ok(f) && !was_busy) begin
         m_fmt = f;
         m_three = t;
         m_shift = s;
         m_comp = 0;
      end
      tick();
      attr_start = 1'b0;
      check("err", 32'(err), 32'(!fmt_ok(f) && !was_busy));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 32'(busy), 0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_fmt_start", 32'(fmt_start), 0);
      check("rst_word_ready", 32'(word_ready), 0);
      check("rst_count", dut_count(), 0);
      #2 resetn = 1'b1;
      tick();
      check("rel_word_ready", 32'(word_ready), 1);

      word_q.push_back(32'h010203AA);
      start_attr(FMT_U8, 1'b1, 5'd0);
      wait_idle("u8x3");
      check("u8x3_count", dut_count(), 1);

      word_q.push_back(32'hFFFE0007);
      start_attr(FMT_S16, 1'b0, 5'd5);
      wait_idle("s16x2");
      check("s16x2_count", dut_count(), 1);

      word_q.push_back(32'h11223344);
      start_attr(FMT_U8, 1'b0, 5'd0);
      wait_idle("u8x2");
      check("pre_flush_count", dut_count(), 3);
      do_flush();
      check("flush_count", dut_count(), 0);

      word_q.push_back(32'h3F800000);
      word_q.push_back(32'h40000000);
      start_attr(FMT_FLOAT, 1'b0, 5'd0);
      wait_idle("float");
      check("float_count", dut_count(), 0);

      start_attr(3'd6, 1'b1, 5'd0);
      check("rsv_busy", 32'(busy), 0);
      tick();
      check("err_pulse_end", 32'(err), 0);

      word_q.push_back(32'hA1B2C3D4);
      start_attr(FMT_U8, 1'b0, 5'd0);
      wait_idle("u8_pre");
      feed_en = 1'b0;
      start_attr(FMT_FLOAT, 1'b0, 5'd0);
      repeat (3) tick();
      do_flush();
      check("flush_busy_busy", 32'(busy), 1);
      check("flush_busy_count", dut_count(), 2);
      word_q.push_back($urandom);
      word_q.push_back($urandom);
      feed_en = 1'b1;
      wait_idle("float_stall");
      check("stall_count", dut_count(), 32'(ref_q.size()));

      rdy_mode = 2;
      repeat (4) word_q.push_back($urandom);
      start_attr(FMT_U16, 1'b1, 5'd3);
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      check("bp_out_valid", 32'(out_valid), 1);
      repeat (5) begin
         tick();
         check("bp_hold_valid", 32'(out_valid), 1);
         check("bp_no_start", 32'(fmt_start), 0);
      end
      check("bp_word_ready", 32'(word_ready), 0);
      check("bp_full", 32'(dut_count() > BUF - 4), 1);
      check("bp_count", dut_count(), 32'(ref_q.size()));
      rdy_mode = 0;
      wait_idle("bp");

      word_q.push_back($urandom);
      word_q.push_back($urandom);
      start_attr(FMT_S16, 1'b1, 5'd1);
      n = 0;
      while (!fmt_start && n < 200) begin
         tick();
         n++;
      end
      check("rst_conv_seen", 32'(fmt_start), 1);
      #2 resetn = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_out_valid", 32'(out_valid), 0);
      check("arst_fmt_start", 32'(fmt_start), 0);
      check("arst_word_ready", 32'(word_ready), 0);
      ref_q.delete();
      word_q.delete();
      outstanding = 0;
      prev_ov = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 resetn = 1'b1;
      tick();
      check("arst_count", dut_count(), 0);
      check("arst_idle", 32'(busy), 0);

      rdy_mode = 1;
      feed_rand = 1'b1;
      repeat (40) begin
         logic [2:0] f;
         f = 3'($urandom_range(5));
         if (f == 3'd5) f = 3'($urandom_range(7, 5));
         if (fmt_ok(f)) repeat (3) word_q.push_back($urandom);
         start_attr(f, 1'($urandom_range(1)), 5'($urandom));
         wait_idle("rand");
         check("rand_count", dut_count(), 32'(ref_q.size()));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/coord_attr_fetcher.md
Name: coord_attr_fetcher

Overview:
- Upstream feeder for the coordinate formatter stage.
- Takes the big-endian 32-bit vertex word stream from the command FIFO and buffers it as bytes.
- Slices out 2 or 3 raw components of the configured format and drives the formatter one component at a time, holding its inputs stable until the formatter reports valid.
- Returns each float result on a valid/ready output channel tagged with the component index.

Parameters:
- BUF_BYTES, 8, byte buffer depth; minimum 8. A word is accepted only when at least 4 bytes are free.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- attr_start  in  1  one-cycle pulse; begin one attribute using cfg_* sampled this cycle
- cfg_format  in  3  0=U8, 1=S8, 2=U16, 3=S16, 4=FLOAT, 5-7 reserved
- cfg_three  in  1  0 = 2 components, 1 = 3 components
- cfg_shift  in  5  fixed-point shift, forwarded to formatter
- flush  in  1  drop all buffered bytes; honoured only while idle
- busy  out  1  attribute in progress
- err  out  1  one-cycle pulse: attr_start with a reserved format
- word_valid  in  1  stream word available
- word_data  in  32  stream word; [31:24] is the first byte
- word_ready  out  1  word accepted when word_valid & word_ready
- fmt_start  out  1  formatter start pulse
- fmt_data  out  32  raw component, right-aligned and zero-extended
- fmt_format  out  3  format to formatter
- fmt_shift  out  5  shift to formatter
- fmt_valid  in  1  formatter result valid
- fmt_result  in  32  formatter float result
- out_valid  out  1  float component available
- out_data  out  32  float component
- out_index  out  2  component index 0..2
- out_last  out  1  final component of the attribute
- out_ready  in  1  consumer accepts the component

Behaviour:
- Reset: all outputs are 0, the byte count is 0 and the FSM is in IDLE. Reset is asynchronous and aborts any operation immediately; buffered bytes are lost.
- Component size: U8/S8 = 1 byte, U16/S16 = 2, FLOAT = 4. Components are packed with no alignment padding.
- Leftover bytes persist across attributes.
- Buffer input:
  - word_ready = (count <= BUF_BYTES-4) in every state, including IDLE.
  - An accepted word appends 4 bytes in stream order.
  - Byte consumption and word append in the same cycle are both honoured. The new count is count - size + 4.
- FSM states and transitions:
  - IDLE:
    - attr_start with format 0-4 latches the cfg fields, sets comp=0 and goes to GATHER.
    - attr_start with format 5-7 pulses err and stays in IDLE.
    - flush sets count=0.
    - If flush and attr_start arrive together, flush applies first, then the start.
  - GATHER:
    - Waits until count >= size.
    - Then removes size bytes from the head, forms fmt_data big-endian (U16 = b0<<8 | b1; FLOAT = b0..b3) and goes to CONVERT.
  - CONVERT:
    - fmt_start = 1 on the first CONVERT cycle only.
    - fmt_data, fmt_format and fmt_shift are held constant for the whole state.
    - The first cycle with fmt_valid=1 captures fmt_result into out_data and goes to OUTPUT. For FLOAT this is the same cycle as fmt_start; for integer formats it is 2 cycles later.
    - fmt_valid outside CONVERT is ignored.
  - OUTPUT:
    - out_valid = 1; out_data, out_index and out_last are held until out_ready.
    - On the handshake: if comp is the last component, go to IDLE; otherwise comp+1 and go to GATHER.
- busy = (state != IDLE).
- attr_start and flush while busy are ignored.
- Latency with data already buffered and out_ready=1:
  - Integer component: 4 cycles from GATHER entry to handshake.
  - FLOAT component: 2 cycles from GATHER entry to handshake.
- Buffer empty mid-attribute: stall in GATHER indefinitely; no timeout.

Decomposition:
- Shared package coord_pkg:
  - format codes FMT_U8..FMT_FLOAT;
  - a size-lookup function (format to byte count);
  - FSM state enum.
  - The formatter uses the same format codes.
- Sub-module byte_stream_buf:
  - byte FIFO with 32-bit push, 1/2/4-byte pop and byte count;
  - big-endian head window output;
  - flush input.
  - Async active-low reset on clk/resetn.

Test Plan:
- U8, 3 components, shift 0, word 0x01_02_03_AA -> fmt_data 0x01, 0x02, 0x03 in order; out_index 0,1,2; out_last only on index 2; 1 byte (0xAA) left, count=1.
- With 0xAA still buffered, S16 2 components, next word 0xFF_FE_00_07 -> components 0xAAFF, 0xFE00; byte 0x07 left (count=1). Confirms unaligned carry-over.
- FLOAT 2 components, words 0x3F800000 and 0x40000000 -> fmt_start and capture in the same cycle; outputs 0x3F800000 then 0x40000000; 2 cycles per component.
- Backpressure: hold out_ready=0 for 5 cycles in OUTPUT -> out_valid and out_data stable; no second fmt_start. Meanwhile word_valid still fills the buffer until count > BUF_BYTES-4.
- attr_start with format 6 -> err pulses 1 cycle, busy stays 0. flush in IDLE with count=3 -> count=0. flush while busy -> no effect.
- Deassert resetn during CONVERT of an S16 component -> busy, out_valid, fmt_start and word_ready go to 0 immediately with no clk edge; count=0 after release.
